// File: rtl/vertex_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vertex_scheduler
// Brief    : Per-frame MVP sequencer: one camera matrix update, then every
//            active vertex fetched from ROM, transformed and written out.
// Revision : 1.0 - initial release
// ============================================================================
module vertex_scheduler #(
    parameter int N_VERT = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              frame_start,
    input  logic [31:0]       cam_x,
    input  logic [31:0]       cam_y,
    input  logic [31:0]       cam_z,
    input  logic [ADDR_W:0]   vcount,
    output logic [ADDR_W-1:0] vrom_addr,
    input  logic [95:0]       vrom_data,
    output logic              mvp_start,
    output logic              mvp_update,
    output logic [31:0]       mvp_x,
    output logic [31:0]       mvp_y,
    output logic [31:0]       mvp_z,
    input  logic              mvp_done,
    input  logic [31:0]       mvp_ox,
    input  logic [31:0]       mvp_oy,
    input  logic [31:0]       mvp_oz,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [9:0]        out_x,
    output logic [8:0]        out_y,
    output logic              out_vis,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        drop_cnt
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_UPD_START  = 4'd1;
    localparam logic [3:0] S_UPD_WAIT   = 4'd2;
    localparam logic [3:0] S_FETCH      = 4'd3;
    localparam logic [3:0] S_FETCH_WAIT = 4'd4;
    localparam logic [3:0] S_XF_START   = 4'd5;
    localparam logic [3:0] S_XF_WAIT    = 4'd6;
    localparam logic [3:0] S_WRITE      = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    localparam logic [ADDR_W:0]       c_NVERT   = (ADDR_W+1)'(N_VERT);
    localparam logic [ADDR_W:0]       c_CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0]     c_IDX_ONE = ADDR_W'(1);
    localparam logic signed [31:0]    c_X_MAX   = 32'sd639;
    localparam logic signed [31:0]    c_Y_MAX   = 32'sd479;

    logic [3:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_vrom_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_guard;
    logic [31:0]       r_mvp_x;
    logic [31:0]       r_mvp_y;
    logic [31:0]       r_mvp_z;
    logic [7:0]        r_drop;

    logic              w_busy;
    logic              w_write;
    logic              w_wait_exit;
    logic              w_last;
    logic              w_vis;
    logic [ADDR_W-1:0] w_idx_next;
    logic              w_unused;

    assign w_busy      = (r_state != S_IDLE);
    assign w_write     = (r_state == S_WRITE);
    // The datapath's done level is still high from its previous run in the
    // first WAIT cycle, so it only counts once the guard has dropped.
    assign w_wait_exit = mvp_done && !r_guard;
    assign w_last      = (({1'b0, r_idx} + c_CNT_ONE) == r_count);
    assign w_idx_next  = r_idx + c_IDX_ONE;
    assign w_vis       = ($signed(mvp_ox) >= 32'sd0) && ($signed(mvp_ox) <= c_X_MAX) &&
                         ($signed(mvp_oy) >= 32'sd0) && ($signed(mvp_oy) <= c_Y_MAX);
    assign w_unused    = ^mvp_oz;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_vrom_addr <= '0;
            r_count     <= '0;
            r_guard     <= 1'b0;
            r_mvp_x     <= '0;
            r_mvp_y     <= '0;
            r_mvp_z     <= '0;
            r_drop      <= '0;
        end else begin
            if (frame_start && w_busy && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_mvp_x <= cam_x;
                        r_mvp_y <= cam_y;
                        r_mvp_z <= cam_z;
                        r_count <= (vcount > c_NVERT) ? c_NVERT : vcount;
                        r_idx   <= '0;
                        r_state <= S_UPD_START;
                    end
                end
                S_UPD_START: begin
                    r_guard <= 1'b1;
                    r_state <= S_UPD_WAIT;
                end
                S_UPD_WAIT: begin
                    r_guard <= 1'b0;
                    if (w_wait_exit) begin
                        if (r_count == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_vrom_addr <= r_idx;
                            r_state     <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    r_state <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    // Operand registers double as the vertex registers.
                    r_mvp_x <= vrom_data[95:64];
                    r_mvp_y <= vrom_data[63:32];
                    r_mvp_z <= vrom_data[31:0];
                    r_state <= S_XF_START;
                end
                S_XF_START: begin
                    r_guard <= 1'b1;
                    r_state <= S_XF_WAIT;
                end
                S_XF_WAIT: begin
                    r_guard <= 1'b0;
                    if (w_wait_exit) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx       <= w_idx_next;
                        r_vrom_addr <= w_idx_next;
                        r_state     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign vrom_addr  = r_vrom_addr;
    assign mvp_start  = (r_state == S_UPD_START) || (r_state == S_XF_START);
    assign mvp_update = (r_state == S_UPD_START) || (r_state == S_UPD_WAIT);
    assign mvp_x      = r_mvp_x;
    assign mvp_y      = r_mvp_y;
    assign mvp_z      = r_mvp_z;
    assign out_we     = w_write;
    assign out_addr   = r_idx;
    assign out_vis    = w_write && w_vis;
    assign out_x      = (w_write && w_vis) ? mvp_ox[9:0] : 10'd0;
    assign out_y      = (w_write && w_vis) ? mvp_oy[8:0] : 9'd0;
    assign busy       = w_busy;
    assign frame_done = (r_state == S_DONE);
    assign drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_vertex_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vertex_scheduler
// Brief    : Self-checking bench for vertex_scheduler with ROM and datapath models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vertex_scheduler;

    localparam int N_VERT = 64;
    localparam int ADDR_W = 6;

    typedef struct packed {
        logic [5:0] addr;
        logic [9:0] x;
        logic [8:0] y;
        logic       vis;
    } wr_t;

    typedef struct {
        int ox; int oy; bit vis; int ex; int ey;
    } vis_vec_t;

    typedef struct {
        int vc; int tu; int tx; int nwr; int cycles;
    } frm_vec_t;

    logic        clock;
    logic        resetn;
    logic        frame_start;
    logic [31:0] cam_x, cam_y, cam_z;
    logic [6:0]  vcount;
    logic [5:0]  vrom_addr;
    logic [95:0] vrom_data;
    logic        mvp_start, mvp_update;
    logic [31:0] mvp_x, mvp_y, mvp_z;
    logic        mvp_done;
    logic [31:0] mvp_ox, mvp_oy, mvp_oz;
    logic        out_we;
    logic [5:0]  out_addr;
    logic [9:0]  out_x;
    logic [8:0]  out_y;
    logic        out_vis, busy, frame_done;
    logic [7:0]  drop_cnt;

    vertex_scheduler #(.N_VERT(N_VERT), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .resetn(resetn), .frame_start(frame_start),
        .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z), .vcount(vcount),
        .vrom_addr(vrom_addr), .vrom_data(vrom_data),
        .mvp_start(mvp_start), .mvp_update(mvp_update),
        .mvp_x(mvp_x), .mvp_y(mvp_y), .mvp_z(mvp_z), .mvp_done(mvp_done),
        .mvp_ox(mvp_ox), .mvp_oy(mvp_oy), .mvp_oz(mvp_oz),
        .out_we(out_we), .out_addr(out_addr), .out_x(out_x), .out_y(out_y),
        .out_vis(out_vis), .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- environment models ----------------
    logic [95:0] rom [N_VERT];
    logic [95:0] rom_snap [N_VERT];
    int          res_ox [N_VERT];
    int          res_oy [N_VERT];
    int          t_upd, t_xf;
    int          dp_cnt;
    logic [5:0]  xf_n;

    always @(posedge clock) vrom_data <= rom[vrom_addr];

    // Datapath: done stays high one stale cycle after a start, then is low
    // until T cycles have passed since the start.
    always @(posedge clock) begin
        if (!resetn) begin
            dp_cnt   <= 0;
            mvp_done <= 1'b1;
            xf_n     <= '0;
            mvp_ox   <= '0;
            mvp_oy   <= '0;
            mvp_oz   <= '0;
        end else if (mvp_start) begin
            dp_cnt <= mvp_update ? t_upd : t_xf;
            if (mvp_update) begin
                xf_n <= '0;
            end else begin
                mvp_ox <= res_ox[xf_n];
                mvp_oy <= res_oy[xf_n];
                mvp_oz <= 32'(xf_n);
                xf_n   <= xf_n + 6'd1;
            end
        end else if (dp_cnt > 0) begin
            dp_cnt   <= dp_cnt - 1;
            mvp_done <= (dp_cnt == 1);
        end
    end

    // ---------------- monitor ----------------
    logic [95:0] upd_q[$];
    logic [95:0] xf_q[$];
    wr_t         wr_q[$];
    int          done_q[$];
    int          busy_cnt = 0;
    int          hold_err = 0;
    logic        hold_on = 1'b0;
    logic        hold_first = 1'b0;
    logic [96:0] hold_val = '0;

    always @(negedge clock) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (frame_done) done_q.push_back(busy_cnt + 1);
        if (out_we) wr_q.push_back(wr_t'({out_addr, out_x, out_y, out_vis}));
        if (!resetn) begin
            hold_on <= 1'b0;
        end else if (mvp_start) begin
            if (mvp_update) upd_q.push_back({mvp_x, mvp_y, mvp_z});
            else            xf_q.push_back({mvp_x, mvp_y, mvp_z});
            hold_val   <= {mvp_update, mvp_x, mvp_y, mvp_z};
            hold_on    <= 1'b1;
            hold_first <= 1'b1;
        end else if (hold_on) begin
            if ({mvp_update, mvp_x, mvp_y, mvp_z} !== hold_val) hold_err <= hold_err + 1;
            hold_first <= 1'b0;
            if (mvp_done && !hold_first) hold_on <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;
    int upd_base, xf_base, wr_base, done_base, busy_base, hold_base;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    function automatic wr_t exp_wr(input int i, input int ox, input int oy);
        wr_t w;
        bit  v;
        v      = (ox >= 0) && (ox <= 639) && (oy >= 0) && (oy <= 479);
        w.addr = 6'(i);
        w.vis  = v;
        w.x    = v ? 10'(ox) : 10'd0;
        w.y    = v ? 9'(oy) : 9'd0;
        return w;
    endfunction

    task automatic start_frame(input int vc, input logic [31:0] cx, cy, cz);
        upd_base  = upd_q.size();
        xf_base   = xf_q.size();
        wr_base   = wr_q.size();
        done_base = done_q.size();
        busy_base = busy_cnt;
        hold_base = hold_err;
        rom_snap  = rom;
        cam_x = cx; cam_y = cy; cam_z = cz;
        vcount = 7'(vc);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic verify_frame(input int vc, input logic [31:0] cx, cy, cz);
        int n, nd, e;
        n  = (vc > N_VERT) ? N_VERT : vc;
        nd = done_q.size() - done_base;
        check("frame_done_count", nd, 1);
        check("frame_length", (nd > 0) ? done_q[done_base] - busy_base : -1,
              3 + t_upd + n * (5 + t_xf));
        check("update_starts", upd_q.size() - upd_base, 1);
        if (upd_q.size() > upd_base)
            check("update_operands", longint'(upd_q[upd_base] === {cx, cy, cz}), 1);
        e = 0;
        if (xf_q.size() - xf_base != n) e = 1000;
        else for (int i = 0; i < n; i++) if (xf_q[xf_base + i] !== rom_snap[i]) e++;
        check("transform_sequence", e, 0);
        e = 0;
        if (wr_q.size() - wr_base != n) e = 1000;
        else for (int i = 0; i < n; i++)
            if (wr_q[wr_base + i] !== exp_wr(i, res_ox[i], res_oy[i])) e++;
        check("write_sequence", e, 0);
        check("operand_hold", hold_err - hold_base, 0);
    endtask

    task automatic finish_frame(input int vc, input logic [31:0] cx, cy, cz);
        int k;
        k = 0;
        while (done_q.size() == done_base && k < 20000) begin
            tick();
            k++;
        end
        tick();
        verify_frame(vc, cx, cy, cz);
        check("idle_after_frame", busy, 0);
    endtask

    task automatic wait_xf(input int cnt);
        int k;
        k = 0;
        while (xf_q.size() - xf_base < cnt && k < 2000) begin
            tick();
            k++;
        end
        check("transform_reached", xf_q.size() - xf_base, cnt);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vis_vec_t vt[8];
        frm_vec_t fv[5];
        logic [31:0] ax, ay, az;
        int vc, k;

        vt[0] = '{639, 479, 1, 639, 479};
        vt[1] = '{640, 0, 0, 0, 0};
        vt[2] = '{-1, 10, 0, 0, 0};
        vt[3] = '{0, 0, 1, 0, 0};
        vt[4] = '{0, 480, 0, 0, 0};
        vt[5] = '{320, -1, 0, 0, 0};
        vt[6] = '{100, 200, 1, 100, 200};
        vt[7] = '{-1000, -1000, 0, 0, 0};

        fv[0] = '{3, 60, 20, 3, 138};
        fv[1] = '{0, 5, 3, 0, 8};
        fv[2] = '{100, 2, 2, 64, 453};
        fv[3] = '{1, 2, 2, 1, 12};
        fv[4] = '{64, 1, 1, 64, 388};

        for (int i = 0; i < N_VERT; i++) begin
            rom[i]    = {$urandom, $urandom, $urandom};
            res_ox[i] = int'($urandom_range(0, 760)) - 60;
            res_oy[i] = int'($urandom_range(0, 600)) - 60;
        end
        resetn = 1'b0; frame_start = 1'b0; vcount = '0;
        cam_x = '0; cam_y = '0; cam_z = '0; t_upd = 4; t_xf = 4;
        repeat (3) tick();
        check("reset_outputs", longint'(|{vrom_addr, mvp_start, mvp_update, mvp_x, mvp_y, mvp_z,
              out_we, out_addr, out_x, out_y, out_vis, busy, frame_done, drop_cnt}), 0);
        resetn = 1'b1;
        tick();

        // frame-level table: count boundaries and exact cycle cost
        for (int i = 0; i < 5; i++) begin
            t_upd = fv[i].tu;
            t_xf  = fv[i].tx;
            start_frame(fv[i].vc, $urandom, $urandom, $urandom);
            check($sformatf("tbl%0d_latency_busy", i), busy, 1);
            finish_frame(fv[i].vc, cam_x, cam_y, cam_z);
            check($sformatf("tbl%0d_writes", i), wr_q.size() - wr_base, fv[i].nwr);
            if (fv[i].nwr > 0)
                check($sformatf("tbl%0d_last_addr", i), wr_q[wr_q.size() - 1].addr, fv[i].nwr - 1);
            if (done_q.size() > done_base)
                check($sformatf("tbl%0d_cycles", i), done_q[done_base] - busy_base, fv[i].cycles);
        end

        // visibility table
        for (int i = 0; i < 8; i++) begin
            res_ox[i] = vt[i].ox;
            res_oy[i] = vt[i].oy;
        end
        t_upd = 3; t_xf = 2;
        start_frame(8, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        finish_frame(8, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        for (int i = 0; i < 8; i++) begin
            if (wr_q.size() > wr_base + i)
                check($sformatf("vis_vec%0d", i),
                      {wr_q[wr_base + i].vis, wr_q[wr_base + i].x, wr_q[wr_base + i].y},
                      {vt[i].vis, 10'(vt[i].ex), 9'(vt[i].ey)});
            else
                check($sformatf("vis_vec%0d_present", i), wr_q.size() - wr_base, i + 1);
        end

        // operand stability: inputs change while the datapath is busy
        t_upd = 30; t_xf = 12;
        ax = $urandom; ay = $urandom; az = $urandom;
        start_frame(4, ax, ay, az);
        repeat (5) tick();
        cam_x = ~ax; cam_y = ~ay; cam_z = ~az;
        wait_xf(1);
        repeat (4) tick();
        rom[0] = {$urandom, $urandom, $urandom};
        wait_xf(2);
        repeat (4) tick();
        rom[1] = {$urandom, $urandom, $urandom};
        finish_frame(4, ax, ay, az);

        // dropped triggers while busy and in the DONE cycle
        t_upd = 300; t_xf = 20;
        ax = $urandom; ay = $urandom; az = $urandom;
        start_frame(3, ax, ay, az);
        frame_start = 1'b1;
        repeat (300) tick();
        frame_start = 1'b0;
        k = 0;
        while (!frame_done && k < 1000) begin
            tick();
            k++;
        end
        verify_frame(3, ax, ay, az);
        frame_start = 1'b1;
        tick();
        check("drop_saturated", drop_cnt, 255);
        check("done_cycle_trigger_dropped", busy, 0);
        t_upd = 5; t_xf = 3;
        ax = $urandom; ay = $urandom; az = $urandom;
        start_frame(2, ax, ay, az);
        check("first_idle_trigger_accepted", busy, 1);
        finish_frame(2, ax, ay, az);

        // reset during vertex 1's transform
        t_upd = 10; t_xf = 20;
        start_frame(3, $urandom, $urandom, $urandom);
        wait_xf(2);
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        check("midframe_reset_outputs", longint'(|{vrom_addr, mvp_start, mvp_update, mvp_x, mvp_y,
              mvp_z, out_we, out_addr, out_x, out_y, out_vis, busy, frame_done, drop_cnt}), 0);
        resetn = 1'b1;
        repeat (60) tick();
        check("no_done_after_reset", done_q.size() - done_base, 0);
        check("no_write_after_reset", wr_q.size() - wr_base, 1);
        ax = $urandom; ay = $urandom; az = $urandom;
        start_frame(3, ax, ay, az);
        finish_frame(3, ax, ay, az);

        // randomized frames against the arithmetic model
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N_VERT; i++) begin
                rom[i]    = {$urandom, $urandom, $urandom};
                res_ox[i] = int'($urandom_range(0, 760)) - 60;
                res_oy[i] = int'($urandom_range(0, 600)) - 60;
            end
            t_upd = int'($urandom_range(1, 8));
            t_xf  = int'($urandom_range(1, 6));
            vc    = int'($urandom_range(0, 70));
            ax = $urandom; ay = $urandom; az = $urandom;
            start_frame(vc, ax, ay, az);
            finish_frame(vc, ax, ay, az);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vertex_scheduler.md
# vertex_scheduler

Sequences the MVP transform datapath for one frame. On a frame trigger it performs one matrix update with the camera position, then streams every active vertex from vertex ROM through the transform. Each screen-space result is written to the vertex output buffer together with an on-screen flag. It sits between the frame timing logic and the MVP datapath, and is the only driver of the datapath's start, update-select and x/y/z inputs.

## Interface
- N_VERT, 64: vertex ROM depth (maximum vertices per frame)
- ADDR_W, 6: vertex address width, clog2(N_VERT)
- clock  in  1  system clock
- resetn  in  1  synchronous, active-low reset; the MVP datapath receives ~resetn at top level
- frame_start  in  1  one-cycle frame trigger pulse
- cam_x, cam_y, cam_z  in  32 each  camera position, IEEE-754 single
- vcount  in  ADDR_W+1  number of active vertices, 0..N_VERT
- vrom_addr  out  ADDR_W  vertex ROM address, registered
- vrom_data  in  96  {x[95:64], y[63:32], z[31:0]}, floats; valid 1 cycle after vrom_addr
- mvp_start  out  1  datapath start pulse
- mvp_update  out  1  1 = rebuild matrix, 0 = transform vertex
- mvp_x, mvp_y, mvp_z  out  32 each  datapath x/y/z operands
- mvp_done  in  1  datapath idle (level)
- mvp_ox, mvp_oy, mvp_oz  in  32 each  signed integer screen results
- out_we  out  1  output buffer write strobe
- out_addr  out  ADDR_W  output buffer address (vertex index)
- out_x  out  10  screen x, 0 when not visible
- out_y  out  9  screen y, 0 when not visible
- out_vis  out  1  1 when 0 ≤ ox ≤ 639 and 0 ≤ oy ≤ 479 (signed compare)
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- drop_cnt  out  8  saturating count of frame_start pulses ignored while busy

## Operation
- States: IDLE, UPD_START, UPD_WAIT, FETCH, FETCH_WAIT, XF_START, XF_WAIT, WRITE, DONE.
- IDLE:
  - On frame_start, latch cam_x/y/z and vcount, clamping vcount to N_VERT.
  - Clear idx to 0 and go to UPD_START.
- UPD_START (1 cycle):
  - mvp_start=1, mvp_update=1, mvp_x/y/z = latched camera position.
- UPD_WAIT:
  - Exit on mvp_done=1, except that mvp_done is ignored in the first cycle after entry.
  - On exit, go to DONE if the latched count is 0, otherwise go to FETCH.
- FETCH (1 cycle): vrom_addr=idx.
- FETCH_WAIT (1 cycle): capture vrom_data into the vertex registers.
- XF_START (1 cycle):
  - mvp_start=1, mvp_update=0, mvp_x/y/z = vertex registers.
- XF_WAIT: same exit rule as UPD_WAIT, then go to WRITE.
- WRITE (1 cycle):
  - out_we=1, out_addr=idx.
  - out_x/out_y/out_vis are derived from mvp_ox/oy as specified.
  - If idx = count-1, go to DONE; otherwise increment idx and go to FETCH.
- DONE (1 cycle): frame_done=1, then go to IDLE.
- Operand hold:
  - mvp_x/y/z are registered and must not change from a START state until the following WAIT state exits.
  - The datapath samples them late in its sequence.
- mvp_update holds its START value through the matching WAIT state. mvp_start is high only in START states.
- out_x = ox[9:0] and out_y = oy[8:0] only when out_vis=1; otherwise both are 0.
- Dropped triggers:
  - frame_start while busy (including the DONE cycle) is ignored and increments drop_cnt, saturating at 255.
  - It never restarts or extends the current frame.
- drop_cnt clears only on reset.

## Timing
- Reset (resetn=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0; mvp_x/y/z go to 0.
  - idx, latched count and drop_cnt go to 0.
- Reset mid-frame aborts with no frame_done and no further writes.
- Latency from the frame_start edge to the UPD_START cycle is 1 cycle.
- Per-vertex cost is 5 + T_xf cycles, where T_xf is the number of datapath busy cycles.
- Frame cost is 3 + T_upd + count·(5 + T_xf), with DONE included.
- vcount=0: the update still runs, then DONE directly, with no out_we.
- vcount > N_VERT: clamped; exactly N_VERT writes, with addresses 0..N_VERT-1.
- frame_start in the same cycle as the DONE→IDLE transition is dropped. A trigger on the first IDLE cycle is accepted.
- mvp_done high in the cycle right after a START state is ignored, guarding against the stale idle level.

## Test plan
- Basic frame:
  - Stimulus: vcount=3, ROM holding three known points, datapath model with T_upd=60 and T_xf=20.
  - Required response: exactly one update start with mvp_update=1 and mvp_x/y/z=cam, then 3 transform starts in address order.
  - out_we appears at addresses 0, 1, 2; frame_done pulses exactly once, 3+60+3·25=138 cycles after acceptance.
- Visibility:
  - Stimulus: model returns (ox,oy) = (639,479), (640,0) and (−1,10).
  - Required response: out_vis = 1, 0, 0; out_x/out_y = 639/479, then 0/0, then 0/0.
- Boundaries:
  - vcount=0: update only, zero writes, frame_done.
  - vcount=100 with N_VERT=64: 64 writes, last out_addr=63.
- Drops:
  - Stimulus: 300 frame_start pulses while busy, plus one in the DONE cycle.
  - Required response: drop_cnt=255 and frame not restarted; a pulse on the next IDLE cycle starts a new frame.
- Operand stability:
  - Stimulus: change cam_x and the ROM contents during UPD_WAIT and XF_WAIT.
  - Required response: mvp_x/y/z unchanged until the WAIT state exits; the stale mvp_done=1 in the first WAIT cycle causes no early exit.
- Reset mid-frame:
  - Stimulus: resetn=0 for 1 cycle during vertex 1's XF_WAIT.
  - Required response: all outputs 0 the next cycle, no frame_done, no further out_we; a fresh frame_start runs a full frame.
